product_collector_taint: RTL

//  Sits directly downstream of the taint-tracked sequential multiplier. Detects each

---
 rtl/product_collector_taint_pkg.sv | 20 ++
 rtl/product_collector_taint_fifo.sv | 75 +++++++
 rtl/product_collector_taint.sv | 101 ++++++++++
 3 files changed

// File: rtl/product_collector_taint_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | product_collector_taint_pkg: shared taint helpers and default sizes       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifndef TAINT_ALL
`define TAINT_ALL(w, b) {(w){(b)}}
`endif

package product_collector_taint_pkg;

  localparam int C_WIDTH_DEF = 8;
  localparam int C_DEPTH_DEF = 4;

  function automatic logic taint_or(input logic a, input logic b);
    return a | b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/product_collector_taint_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | taint_fifo: FWFT FIFO holding data plus a bitwise taint shadow per entry  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module taint_fifo
  import product_collector_taint_pkg::*;
#(
  parameter int DW    = 2 * C_WIDTH_DEF,
  parameter int DEPTH = C_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] data_t_i,
  output logic [DW-1:0] head_o,
  output logic [DW-1:0] head_t_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q   [DEPTH];
  logic [DW-1:0] mem_t_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop_w, push_w;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign pop_w   = pop_i & ~empty_o;
  assign push_w  = push_i & (~full_o | pop_w);

  always_comb begin
    count_d = count_q;
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]   <= '0;
        mem_t_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push_w) begin
        mem_q[wr_q]   <= data_i;
        mem_t_q[wr_q] <= data_t_i | `TAINT_ALL(DW, 1'b0);
        wr_q          <= wr_q + AW'(1);
      end
      if (pop_w) begin
        rd_q <= rd_q + AW'(1);
      end
    end
  end

  assign head_o   = mem_q[rd_q];
  assign head_t_o = mem_t_q[rd_q];
  assign count_o  = count_q;

endmodule
`default_nettype wire

// File: rtl/product_collector_taint.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | product_collector_taint: captures multiplier products into a taint FIFO  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module product_collector_taint
  import product_collector_taint_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEF,
  parameter int DEPTH = C_DEPTH_DEF,
  localparam int DW   = 2 * WIDTH,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          productDone,
  input  logic          productDone_t,
  input  logic [DW-1:0] product,
  input  logic [DW-1:0] product_t,
  input  logic          out_ready,
  input  logic          out_ready_t,
  output logic          out_valid,
  output logic          out_valid_t,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] out_data_t,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          overflow_t
);

  logic          done_q, done_t_q;
  logic          ctrl_taint_q, ctrl_taint_d;
  logic          overflow_q, overflow_t_q;
  logic          cap, cap_t, push, pop, drop, full, empty;
  logic          taint_set, taint_clr;
  logic [DW-1:0] head, head_t, push_t;
  logic [CW-1:0] fifo_count;

  assign cap    = productDone & ~done_q;
  assign cap_t  = taint_or(productDone_t, done_t_q);
  assign pop    = out_valid & out_ready;
  assign push   = cap & (~full | pop);
  assign drop   = cap & full & ~pop;
  assign push_t = product_t | `TAINT_ALL(DW, cap_t);

  taint_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   (product),
    .data_t_i (push_t),
    .head_o   (head),
    .head_t_o (head_t),
    .count_o  (fifo_count),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Setting wins over clearing so a tainted decision is never forgotten.
  assign taint_set = cap_t | (out_ready_t & out_valid);
  assign taint_clr = pop & ~push & ~out_ready_t & (fifo_count == CW'(1));

  always_comb begin
    ctrl_taint_d = ctrl_taint_q;
    if (taint_set) begin
      ctrl_taint_d = 1'b1;
    end else if (taint_clr) begin
      ctrl_taint_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q       <= 1'b0;
      done_t_q     <= 1'b0;
      ctrl_taint_q <= 1'b0;
      overflow_q   <= 1'b0;
      overflow_t_q <= 1'b0;
    end else begin
      done_q       <= productDone;
      done_t_q     <= productDone_t;
      ctrl_taint_q <= ctrl_taint_d;
      overflow_q   <= overflow_q | drop;
      overflow_t_q <= taint_or(overflow_t_q, drop & cap_t);
    end
  end

  assign out_valid   = ~empty;
  assign out_valid_t = ctrl_taint_q;
  assign out_data    = empty ? '0 : head;
  assign out_data_t  = empty ? '0 : (head_t | `TAINT_ALL(DW, ctrl_taint_q));
  assign count       = fifo_count;
  assign overflow    = overflow_q;
  assign overflow_t  = overflow_t_q;

endmodule
`default_nettype wire
